// File: rtl/counter_pkg.sv
// Shared mode constants and parameter-legality helper for the up/down modulo counter.
package counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // True when MODULUS fits the configured width and spans at least two states.
  function automatic bit counter_params_legal(input int width, input int modulus);
    return (width >= 1) && (width <= 31) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

  // True when the saturate parameter names one of the two supported modes.
  function automatic bit counter_mode_legal(input int mode);
    return (mode == MODE_WRAP) || (mode == MODE_SAT);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enabled-cycle prescaler: tick fires on the enabled cycle where the phase reaches div.
import counter_pkg::*;

module counter_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_enable,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] r_phase;
  logic                  w_tick;

  // >= so a div lowered below the current phase ticks on the next enabled cycle
  assign w_tick = i_enable && (r_phase >= i_div);
  assign o_tick = w_tick;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_phase <= '0;
    end else if (w_tick) begin
      r_phase <= '0;
    end else if (i_enable) begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down modulo counter with load, clear, wrap/saturate and overflow/underflow pulses.
// Optional enabled-cycle prescaler is built when COUNTER_PRESCALE_EN is defined.
import counter_pkg::*;

module mod_updown_counter #(
  parameter int WIDTH      = 8,
  parameter int MODULUS    = 256,
  parameter int SATURATE   = 0,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  enable,
  input  logic                  up_dn,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  localparam bit               SAT_EN  = (SATURATE == MODE_SAT);

  generate
    if (!counter_params_legal(WIDTH, MODULUS) || !counter_mode_legal(SATURATE)) begin : g_bad_params
      $error("mod_updown_counter: illegal WIDTH/MODULUS/SATURATE combination");
    end
  endgenerate

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_tick;
  logic             w_step;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_ovf_nxt;
  logic             w_unf_nxt;

`ifdef COUNTER_PRESCALE_EN
  // Any clear or load restarts the step period as well as the count
  counter_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (clear || load),
    .i_enable (enable),
    .i_div    (prescale_div),
    .o_tick   (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_step         = enable && w_tick;
  assign w_load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

  always_comb begin
    w_count_nxt = r_count;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (clear) begin
      w_count_nxt = '0;
    end else if (load) begin
      w_count_nxt = w_load_clamped;
    end else if (w_step) begin
      if (up_dn) begin
        // Explicit compare at the range end; never rely on 2**WIDTH rollover
        if (r_count >= MAX_CNT) begin
          w_ovf_nxt   = 1'b1;
          w_count_nxt = SAT_EN ? MAX_CNT : '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end else begin
        if (r_count == '0) begin
          w_unf_nxt   = 1'b1;
          w_count_nxt = SAT_EN ? '0 : MAX_CNT;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  assign count     = r_count;
  assign overflow  = r_ovf;
  assign underflow = r_unf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations driven in parallel against a behavioural model.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       enable = 1'b0;
  logic       up_dn = 1'b0;
  logic [3:0] pdiv = 4'd0;

  logic [7:0] cnt_o [3];
  logic       ovf_o [3];
  logic       unf_o [3];

  int  nchecks = 0;
  int  nerrors = 0;
  bit  chk_on = 1'b0;

  // model state: index 0 = MOD 10 wrap, 1 = MOD 10 saturate, 2 = MOD 100 wrap
  int  mod_t [3] = '{10, 10, 100};
  bit  sat_t [3] = '{1'b0, 1'b1, 1'b0};
  int  m_cnt [3];
  bit  m_ovf [3];
  bit  m_unf [3];
  int  m_phase = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(0), .PRESCALE_W(4)) dut_w (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn),
`ifdef COUNTER_PRESCALE_EN
    .prescale_div(pdiv),
`endif
    .count(cnt_o[0]), .overflow(ovf_o[0]), .underflow(unf_o[0]));

  mod_updown_counter #(.WIDTH(8), .MODULUS(10), .SATURATE(1), .PRESCALE_W(4)) dut_s (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn),
`ifdef COUNTER_PRESCALE_EN
    .prescale_div(pdiv),
`endif
    .count(cnt_o[1]), .overflow(ovf_o[1]), .underflow(unf_o[1]));

  mod_updown_counter #(.WIDTH(8), .MODULUS(100), .SATURATE(0), .PRESCALE_W(4)) dut_l (
    .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn),
`ifdef COUNTER_PRESCALE_EN
    .prescale_div(pdiv),
`endif
    .count(cnt_o[2]), .overflow(ovf_o[2]), .underflow(unf_o[2]));

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural next-state: priority rst > clear > load > step, pulses only on a boundary step.
  task automatic model_step();
    bit tick;
    tick = 1'b1;
`ifdef COUNTER_PRESCALE_EN
    tick = enable && (m_phase >= int'(pdiv));
    if (rst || clear || load) m_phase = 0;
    else if (tick)            m_phase = 0;
    else if (enable)          m_phase = m_phase + 1;
`endif
    for (int i = 0; i < 3; i++) begin
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      if (rst || clear) begin
        m_cnt[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > mod_t[i] - 1) ? mod_t[i] - 1 : int'(load_val);
      end else if (enable && tick) begin
        if (up_dn) begin
          if (m_cnt[i] == mod_t[i] - 1) begin
            m_ovf[i] = 1'b1;
            if (!sat_t[i]) m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            m_unf[i] = 1'b1;
            if (!sat_t[i]) m_cnt[i] = mod_t[i] - 1;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit c, input bit l, input int lv, input bit e, input bit u);
    @(negedge clk);
    rst = r; clear = c; load = l; load_val = 8'(lv); enable = e; up_dn = u;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Continuous comparison of every instance against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_count[%0d]", i), int'(cnt_o[i]), m_cnt[i]);
        chk($sformatf("model_ovf[%0d]", i), int'(ovf_o[i]), int'(m_ovf[i]));
        chk($sformatf("model_unf[%0d]", i), int'(unf_o[i]), int'(m_unf[i]));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    chk("reset_count", int'(cnt_o[2]), 0);
    chk("reset_ovf", int'(ovf_o[2]), 0);
    chk("reset_unf", int'(unf_o[2]), 0);

    // rst with count=37
    cyc(0, 0, 1, 37, 0, 0);
    chk("load37", int'(cnt_o[2]), 37);
    chk("load37_clamp_mod10", int'(cnt_o[0]), 9);
    cyc(1, 0, 0, 0, 1, 1);
    chk("rst_from_37", int'(cnt_o[2]), 0);
    chk("rst_from_37_ovf", int'(ovf_o[2]), 0);

    // up from 9: wrap vs saturate
    cyc(0, 0, 1, 9, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("wrap_up_count", int'(cnt_o[0]), 0);
    chk("wrap_up_ovf", int'(ovf_o[0]), 1);
    chk("sat_up_count", int'(cnt_o[1]), 9);
    chk("sat_up_ovf", int'(ovf_o[1]), 1);
    chk("mod100_up_count", int'(cnt_o[2]), 10);
    chk("mod100_up_ovf", int'(ovf_o[2]), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("ovf_one_cycle", int'(ovf_o[0]), 0);
    chk("hold_when_disabled", int'(cnt_o[0]), 0);

    // down from 0
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("wrap_dn_count", int'(cnt_o[0]), 9);
    chk("wrap_dn_unf", int'(unf_o[0]), 1);
    chk("sat_dn_count", int'(cnt_o[1]), 0);
    chk("sat_dn_unf", int'(unf_o[1]), 1);
    chk("mod100_dn_count", int'(cnt_o[2]), 99);

    // load beats step, clamps to MODULUS-1
    cyc(0, 0, 1, 200, 1, 1);
    chk("load200_count", int'(cnt_o[2]), 99);
    chk("load200_no_ovf", int'(ovf_o[2]), 0);
    chk("load200_no_unf", int'(unf_o[2]), 0);
    cyc(0, 1, 1, 50, 1, 1);
    chk("clear_over_load", int'(cnt_o[2]), 0);

`ifdef COUNTER_PRESCALE_EN
    @(negedge clk) pdiv = 4'd3;
    cyc(0, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      if (k == 3) chk("presc_before_tick", int'(cnt_o[2]), 0);
      if (k == 4) chk("presc_tick4", int'(cnt_o[2]), 1);
      if (k == 8) chk("presc_tick8", int'(cnt_o[2]), 2);
    end
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 1, 0, 0, 1, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 1, 1);
      if (k == 3) chk("presc_restart_wait", int'(cnt_o[2]), 0);
      if (k == 4) chk("presc_restart_tick", int'(cnt_o[2]), 1);
    end
`endif

    // randomized traffic
    for (int n = 0; n < 10000; n++) begin
`ifdef COUNTER_PRESCALE_EN
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk) pdiv = 4'($urandom_range(0, 3));
      end
`endif
      cyc(($urandom_range(0, 499) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 19) == 0), int'($urandom_range(0, 255)),
          ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
